// File: rtl/gate_check_pkg.sv
// Shared codes, FSM encoding and truth tables
// for the two-input gate truth checker.
package gate_check_pkg;

  typedef enum logic [2:0] {
    GATE_AND   = 3'd0,
    GATE_OR    = 3'd1,
    GATE_NAND  = 3'd2,
    GATE_NOR   = 3'd3,
    GATE_XOR   = 3'd4,
    GATE_XNOR  = 3'd5,
    GATE_BUF_A = 3'd6,
    GATE_NOT_A = 3'd7
  } gate_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Expected y for every input vector, bit index = {a,b}
  function automatic logic [3:0] truth_table(
    input gate_e sel
  );
    logic [3:0] t;
    t = 4'b0000;
    unique case (sel)
      GATE_AND:   t = 4'b1000;
      GATE_OR:    t = 4'b1110;
      GATE_NAND:  t = 4'b0111;
      GATE_NOR:   t = 4'b0001;
      GATE_XOR:   t = 4'b0110;
      GATE_XNOR:  t = 4'b1001;
      GATE_BUF_A: t = 4'b1100;
      GATE_NOT_A: t = 4'b0011;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gate_truth_checker.sv
// Walks an external 2-input gate through all four
// vectors and compares y against the chosen function.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] LP_LAST =
    4'(SETTLE_CYCLES - 1);

  state_e     r_state;
  state_e     w_next;
  gate_e      r_sel;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_err;
  logic [3:0] r_fail;
  logic       r_pass;
  logic       r_done;
  logic       r_busy;
  logic       r_a;
  logic       r_b;

  logic       w_accept;
  logic       w_settled;
  logic       w_drv;
  logic [3:0] w_table;
  logic       w_exp;
  logic       w_miss;

  // The output register for busy lags the state, so
  // the IDLE cycle right after REPORT still rejects start.
  assign w_accept  = (r_state == ST_IDLE) && start
                     && !r_busy;
  assign w_settled = (r_cnt == LP_LAST);
  assign w_drv     = (r_state == ST_DRIVE)
                     || (r_state == ST_SAMPLE);
  assign w_table   = truth_table(r_sel);
  assign w_exp     = w_table[r_idx];
  assign w_miss    = (r_state == ST_SAMPLE)
                     && (y != w_exp);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (w_settled) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (r_idx == 2'd3) w_next = ST_REPORT;
        else               w_next = ST_DRIVE;
      end
      ST_REPORT: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, vector walk, result capture and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= GATE_AND;
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
      r_err   <= 3'd0;
      r_fail  <= 4'd0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_REPORT);
      r_busy  <= (r_state != ST_IDLE);
      r_a     <= w_drv ? r_idx[1] : 1'b0;
      r_b     <= w_drv ? r_idx[0] : 1'b0;

      if ((r_state == ST_DRIVE) && !w_settled)
        r_cnt <= r_cnt + 4'd1;
      else
        r_cnt <= 4'd0;

      if (w_accept) begin
        r_sel  <= gate_e'(gate_sel);
        r_idx  <= 2'd0;
        r_err  <= 3'd0;
        r_fail <= 4'd0;
        r_pass <= 1'b0;
      end else begin
        if (r_state == ST_SAMPLE)
          r_idx <= r_idx + 2'd1;
        if (w_miss) begin
          r_err         <= r_err + 3'd1;
          r_fail[r_idx] <= 1'b1;
        end
        if (r_state == ST_REPORT)
          r_pass <= (r_err == 3'd0);
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized bench for gate_truth_checker with a
// behavioural gate model and device-under-check stub.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] gsel;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [2:0] err;
  logic [3:0] fv;
  logic [3:0] dev;

  logic       start1;
  logic [2:0] gsel1;
  logic       a1, b1, y1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign y  = dev[{a, b}];
  assign y1 = ~(a1 & b1);

  gate_truth_checker #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .gate_sel(gsel), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err), .fail_vec(fv)
  );

  gate_truth_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .gate_sel(gsel1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic ref_y(
    input int   sel,
    input logic va,
    input logic vb
  );
    case (sel)
      0:       return va & vb;
      1:       return va | vb;
      2:       return !(va & vb);
      3:       return !(va | vb);
      4:       return va ^ vb;
      5:       return va == vb;
      6:       return va;
      default: return !va;
    endcase
  endfunction

  // One run on the SETTLE_CYCLES=2 instance.
  task automatic run0(
    input string      tag,
    input int         sel,
    input logic [3:0] devtab,
    input bit         disturb
  );
    logic [3:0] efv;
    int         eerr;
    int         done_at;
    int         ndone;
    logic [1:0] seq[$];
    logic       va, vb;
    efv  = 4'd0;
    eerr = 0;
    for (int v = 0; v < 4; v++) begin
      va = v[1];
      vb = v[0];
      if (ref_y(sel, va, vb) != devtab[v]) begin
        efv[v] = 1'b1;
        eerr++;
      end
    end
    done_at = -1;
    ndone   = 0;
    @(negedge clk);
    dev   = devtab;
    gsel  = 3'(sel);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (disturb && n == 4) start = 1'b1;
      if (disturb && n == 5) begin
        start = 1'b0;
        gsel  = 3'd0;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = n;
          chk({tag, "_pass"}, 32'(pass),
              32'(eerr == 0));
          chk({tag, "_err"}, 32'(err), 32'(eerr));
          chk({tag, "_fv"}, 32'(fv), 32'(efv));
          chk({tag, "_ab_rep"}, 32'({a, b}), 0);
        end
      end
      if (busy && !done &&
          (seq.size() == 0 || seq[$] != {a, b}))
        seq.push_back({a, b});
    end
    chk({tag, "_lat"}, 32'(done_at), 13);
    chk({tag, "_ndone"}, 32'(ndone), 1);
    chk({tag, "_seqn"}, 32'(seq.size()), 4);
    for (int i = 0; i < seq.size() && i < 4; i++)
      chk({tag, "_seq"}, 32'(seq[i]), 32'(i));
    chk({tag, "_hold"},
        32'({busy, pass, err, fv}),
        32'({1'b0, eerr == 0, 3'(eerr), efv}));
  endtask

  initial begin
    int nd;
    int d1;
    logic [3:0] rt;
    int rs;
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    gsel   = 3'd0;
    gsel1  = 3'd2;
    dev    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'({a, b, busy, done,
                      pass, err, fv}), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    run0("nand_ok", 2, 4'b0111, 1'b0);
    run0("and_vs_nand", 0, 4'b0111, 1'b0);
    run0("nor_tie0", 3, 4'b0000, 1'b0);
    run0("disturb", 2, 4'b0111, 1'b1);

    // Reset during a run
    @(negedge clk);
    dev   = 4'b0000;
    gsel  = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid", 32'({a, b, busy, done,
                        pass, err, fv}), 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("rst_nodone", 32'(nd), 0);
    run0("after_rst", 2, 4'b0111, 1'b0);

    // Start held high: back-to-back runs
    @(negedge clk);
    dev   = 4'b0111;
    gsel  = 3'd2;
    start = 1'b1;
    nd = 0;
    for (int n = 0; n < 36; n++) begin
      @(posedge clk);
      #1 if (done) begin
        nd++;
        chk("b2b_pass", 32'(pass), 1);
      end
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(nd), 2);
    repeat (20) @(negedge clk);

    for (int r = 0; r < 12; r++) begin
      rs = int'($urandom_range(0, 7));
      rt = 4'($urandom);
      if ($urandom_range(0, 2) == 0)
        for (int v = 0; v < 4; v++)
          rt[v] = ref_y(rs, v[1], v[0]);
      run0("rand", rs, rt, 1'b0);
    end

    // SETTLE_CYCLES=1 instance
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    d1 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1 if (done1 && d1 < 0) begin
        d1 = n;
        chk("s1_res", 32'({pass1, err1, fv1}),
            32'({1'b1, 3'd0, 4'd0}));
      end
    end
    chk("s1_lat", 32'(d1), 9);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: clocks each stimulus vector is held before y is sampled; legal range 1..15.
REQ-002 The block SHALL have one clock, clk, and its reset, rst, SHALL be asynchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  run request, sampled in IDLE only.
- gate_sel  input  3  expected gate function, captured on start.
- a  output  1  stimulus to device-under-check input a.
- b  output  1  stimulus to device-under-check input b.
- y  input  1  response from device-under-check.
- busy  output  1  high from the cycle after start acceptance through the REPORT cycle.
- done  output  1  one-cycle pulse in the REPORT cycle.
- pass  output  1  1 when the last run had zero mismatches.
- err_count  output  3  mismatch count of the last run, 0..4.
- fail_vec  output  4  bit {a,b} set when that vector mismatched.

Function
REQ-004 gate_sel encoding SHALL be: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF_A (y=a), 7 NOT_A (y=~a).
REQ-005 The expected 4-bit table, indexed by {a,b}, SHALL be: AND 1000, OR 1110, NAND 0111, NOR 0001, XOR 0110, XNOR 1001, BUF_A 1100, NOT_A 0011.
REQ-006 The FSM SHALL have states IDLE, DRIVE, SAMPLE and REPORT.
REQ-007 In IDLE with start=1: latch gate_sel, clear err_count and fail_vec, set vector index to 0, and go to DRIVE.
REQ-008 In DRIVE: a and b SHALL equal index bits [1] and [0]; the state SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-009 In SAMPLE: compare y against the expected bit. On mismatch, increment err_count and set fail_vec[index]. If index=3, go to REPORT; otherwise increment index and go to DRIVE.
REQ-010 In REPORT: assert done for one cycle, assert pass iff err_count=0, then return to IDLE.
REQ-011 done SHALL rise 4*(SETTLE_CYCLES+1)+1 rising edges after the edge that accepted start; this is 13 edges for the default.
REQ-012 start SHALL be ignored while busy=1; start held high continuously SHALL launch back-to-back runs, one per IDLE visit.
REQ-013 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-014 gate_sel changes during a run SHALL have no effect.
REQ-015 All outputs SHALL be registered; a and b SHALL be 0 in IDLE and REPORT.
REQ-016 y SHALL be used only in SAMPLE.

Reset
REQ-017 rst=1 SHALL immediately force: state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, index=0, settle counter=0.
REQ-018 A reset during a run SHALL abort it with no done pulse; the first start after reset release SHALL begin a fresh run from vector 00.

Structure
REQ-019 A shared package gate_check_pkg SHALL hold the gate_sel codes, the FSM state encoding, and the expected-truth-table lookup function.
REQ-020 No sub-module SHALL be instantiated.
REQ-021 The checked gate (e.g. nand_gate) SHALL be external and connected only by the bench or top level.

Verification
REQ-022 nand_gate connected, gate_sel=2, pulse start -> a,b step 00,01,10,11; at edge 13: done=1, pass=1, err_count=0, fail_vec=0000.
REQ-023 nand_gate connected, gate_sel=0 (AND), start -> done: pass=0, err_count=4, fail_vec=1111.
REQ-024 y tied 0, gate_sel=3 (NOR), start -> done: err_count=1, fail_vec=0001, pass=0.
REQ-025 nand_gate connected, gate_sel=2: start; pulse start again at edge 5; change gate_sel to 0 at edge 6 -> single done at edge 13 with pass=1; no second run starts.
REQ-026 Run started; rst asserted at edge 7 -> all outputs 0 immediately; no done pulse; a new start then yields done 13 edges later.
REQ-027 SETTLE_CYCLES=1, nand_gate connected, gate_sel=2 -> done at edge 9, pass=1.
